// File: rtl/vga_out_de2.sv
// 640x480@60 timing from a 50 MHz clock with a 25 MHz pixel enable; colour and syncs to the ADV7123 DAC.
// One pixel (2 clk) from pixel_x/pixel_y to the pins for colour, blank and syncs. No backpressure: free-running.
module vga_out_de2 #(
    parameter int HD = 640,
    parameter int HF = 16,
    parameter int HB = 48,
    parameter int HR = 96,
    parameter int VD = 480,
    parameter int VF = 10,
    parameter int VB = 33,
    parameter int VR = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] color_in,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        video_on,
    output logic        p_tick,
    output logic        frame_tick,
    output logic [9:0]  vga_r,
    output logic [9:0]  vga_g,
    output logic [9:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_blank_n,
    output logic        vga_sync_n,
    output logic        vga_clk
);
    localparam logic [9:0] H_LAST   = 10'(HD + HF + HB + HR - 1);
    localparam logic [9:0] V_LAST   = 10'(VD + VF + VB + VR - 1);
    localparam logic [9:0] H_VIS    = 10'(HD);
    localparam logic [9:0] V_VIS    = 10'(VD);
    localparam logic [9:0] HS_FIRST = 10'(HD + HF);
    localparam logic [9:0] HS_LAST  = 10'(HD + HF + HR - 1);
    localparam logic [9:0] VS_FIRST = 10'(VD + VF);
    localparam logic [9:0] VS_LAST  = 10'(VD + VF + VR - 1);

    logic       r_mod2;
    logic       r_vga_clk;
    logic [9:0] r_h;
    logic [9:0] r_v;
    logic [9:0] r_r;
    logic [9:0] r_g;
    logic [9:0] r_b;
    logic       r_blank_n;
    logic       r_hsync;
    logic       r_vsync;

    logic       w_h_end;
    logic       w_v_end;
    logic       w_video;
    logic       w_hsync;
    logic       w_vsync;

    assign w_h_end = (r_h == H_LAST);
    assign w_v_end = (r_v == V_LAST);
    assign w_video = (r_h < H_VIS) && (r_v < V_VIS);
    assign w_hsync = ~((r_h >= HS_FIRST) && (r_h <= HS_LAST));
    assign w_vsync = ~((r_v >= VS_FIRST) && (r_v <= VS_LAST));

    // vga_clk tracks the mod-2 register, so it rises one clk after the output registers update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mod2    <= 1'b0;
            r_vga_clk <= 1'b0;
        end else begin
            r_mod2    <= ~r_mod2;
            r_vga_clk <= ~r_mod2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h <= 10'd0;
            r_v <= 10'd0;
        end else if (r_mod2) begin
            if (w_h_end) begin
                r_h <= 10'd0;
                if (w_v_end) begin
                    r_v <= 10'd0;
                end else begin
                    r_v <= r_v + 10'd1;
                end
            end else begin
                r_h <= r_h + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_r       <= 10'd0;
            r_g       <= 10'd0;
            r_b       <= 10'd0;
            r_blank_n <= 1'b0;
            r_hsync   <= 1'b1;
            r_vsync   <= 1'b1;
        end else if (r_mod2) begin
            r_r       <= w_video ? color_in[29:20] : 10'd0;
            r_g       <= w_video ? color_in[19:10] : 10'd0;
            r_b       <= w_video ? color_in[9:0]   : 10'd0;
            r_blank_n <= w_video;
            r_hsync   <= w_hsync;
            r_vsync   <= w_vsync;
        end
    end

    assign pixel_x     = r_h;
    assign pixel_y     = r_v;
    assign video_on    = w_video;
    assign p_tick      = r_mod2;
    assign frame_tick  = r_mod2 && (r_h == 10'd0) && (r_v == 10'd0);
    assign vga_r       = r_r;
    assign vga_g       = r_g;
    assign vga_b       = r_b;
    assign vga_hsync   = r_hsync;
    assign vga_vsync   = r_vsync;
    assign vga_blank_n = r_blank_n;
    assign vga_sync_n  = 1'b0;
    assign vga_clk     = r_vga_clk;
endmodule
